// File: rtl/sp_ram_burst_rd_pkg.sv
// -----------------------------------------------------------------------------
// sp_ram_rd_pkg
// Shared definitions for the single-port RAM burst read master:
//   rd_state_t    - burst FSM state encoding (IDLE/RUN/DRAIN/DONE)
//   RAM_RD_LAT    - fixed RAM read latency in cycles (address to data)
//   RD_FIFO_DEPTH - response FIFO depth, which is also the credit limit
// Optional feature macro used by the top: SP_RAM_RD_LAST_EN (adds m_last).
// -----------------------------------------------------------------------------
package sp_ram_rd_pkg;

    localparam int RAM_RD_LAT    = 2;
    localparam int RD_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/sp_ram_burst_rd_fifo.sv
// -----------------------------------------------------------------------------
// sp_ram_rd_fifo
// Small synchronous FIFO holding RAM read responses until downstream takes them.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset (flushes pointers/count)
//   push       - write push_data this cycle (ignored when full)
//   push_data  - word to store
//   pop        - remove the head word this cycle (ignored when empty)
//   head       - current head word (valid while !empty)
//   count      - number of stored words, 0..DEPTH
//   empty      - no words stored
// -----------------------------------------------------------------------------
module sp_ram_rd_fifo #(
    parameter  int DW    = 4,
    parameter  int DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_q];
    assign count   = count_q;

    // Pointer wrap is explicit so a non-power-of-two depth still works.
    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push_ok) begin
            wr_d = (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_d = (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        end
        // Simultaneous push and pop leaves the count unchanged.
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: clearing the pointers and count discards it.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= push_data;
        end
    end

endmodule

// File: rtl/sp_ram_burst_rd.sv
// -----------------------------------------------------------------------------
// sp_ram_burst_rd
// Burst read master for a registered-input single-port RAM. A start command
// streams len consecutive words from base_addr onto a valid/ready stream.
// Reads are credit-limited so that stored plus in-flight words never exceed
// the response FIFO depth; backpressure therefore never drops data.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   start, base_addr,   - command strobe and parameters (sampled in IDLE only)
//   len
//   busy, done          - busy from the cycle after accept; done one-cycle pulse
//   ram_we, ram_addr,   - RAM port (write enable and write data tied to 0)
//   ram_din, ram_dout
//   m_valid, m_ready,   - output stream, words in address order
//   m_data
//   m_last              - only when SP_RAM_RD_LAST_EN is defined: final word
// Timing, counted in edges after the accepting edge: first m_valid after 3,
// done after len+3 with m_ready held high. A zero-length command goes
// straight to DONE, so done follows the accepting edge with no reads.
// -----------------------------------------------------------------------------
module sp_ram_burst_rd
    import sp_ram_rd_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 4,
    parameter int LW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data
`ifdef SP_RAM_RD_LAST_EN
    ,
    output logic          m_last
`endif
);

    localparam int         CW      = $clog2(RD_FIFO_DEPTH + 1);
    localparam logic [CW:0] CREDITS = (CW + 1)'(RD_FIFO_DEPTH);

    rd_state_t             state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [LW-1:0]         left_q, left_d;
    logic [RAM_RD_LAT-1:0] infl_q, infl_d;
    logic [CW-1:0]         infl_cnt;
    logic [CW-1:0]         fifo_count;
    logic                  fifo_empty;
    logic [DW-1:0]         fifo_head;
    logic                  credit_ok;
    logic                  issue;
    logic                  push;
    logic                  pop;

    assign ram_we   = 1'b0;
    assign ram_din  = '0;
    assign ram_addr = addr_q;
    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign m_valid  = !fifo_empty;
    assign m_data   = fifo_head;
    assign pop      = m_valid && m_ready;
    // The oldest in-flight read lines up with ram_dout this cycle.
    assign push     = infl_q[RAM_RD_LAT-1];

    always_comb begin
        infl_cnt = '0;
        for (int i = 0; i < RAM_RD_LAT; i++) begin
            infl_cnt = infl_cnt + CW'(infl_q[i]);
        end
    end

    assign credit_ok = ({1'b0, fifo_count} + {1'b0, infl_cnt}) < CREDITS;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        addr_d  = base_addr;
                        left_d  = len;
                        state_d = RUN;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            RUN: begin
                if (credit_ok) begin
                    issue  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    left_d = left_q - 1'b1;
                    if (left_q == LW'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave as the last stored word is taken, so done lands in
                // the cycle right after the final handshake.
                if ((infl_q == '0) &&
                    (fifo_empty || ((fifo_count == CW'(1)) && pop))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        infl_d = {infl_q[RAM_RD_LAT-2:0], issue};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            left_q  <= '0;
            infl_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            left_q  <= left_d;
            infl_q  <= infl_d;
        end
    end

    sp_ram_rd_fifo #(
        .DW    (DW),
        .DEPTH (RD_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (ram_dout),
        .pop       (pop),
        .head      (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty)
    );

`ifdef SP_RAM_RD_LAST_EN
    // Beat counter tracks handshakes so the final word can be flagged.
    logic [LW-1:0] beat_q, beat_d;
    logic [LW-1:0] len_q, len_d;

    always_comb begin
        beat_d = beat_q;
        len_d  = len_q;
        if ((state_q == IDLE) && start) begin
            beat_d = '0;
            len_d  = len;
        end else if (pop) begin
            beat_d = beat_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
            len_q  <= '0;
        end else begin
            beat_q <= beat_d;
            len_q  <= len_d;
        end
    end

    assign m_last = m_valid && (beat_q == (len_q - 1'b1));
`endif

endmodule
